// File: rtl/uart_pkg.sv
// Shared UART constants and types for the receive path and the programmable-baud transmitter.
// Pure declarations: no latency, no backpressure.
package uart_pkg;

    localparam int DIV_W     = 13;
    localparam int DATA_BITS = 8;

    // One reset divisor for both directions so an unprogrammed link still agrees on baud.
    localparam logic [DIV_W-1:0] RST_DIV    = 13'h01B2;
    localparam logic [DIV_W-1:0] TX_RST_DIV = RST_DIV;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    function automatic logic [DIV_W-1:0] half_period(input logic [DIV_W-1:0] div);
        return div >> 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Three-flop synchronizer (reset to 1) with falling-edge detect; rx_s lags the pin by 2 clocks.
// No backpressure: free-running, start_edge is a single-cycle pulse.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rx_s,
    output logic start_edge
);

    logic ff1;
    logic ff2;
    logic ff3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1 <= 1'b1;
            ff2 <= 1'b1;
            ff3 <= 1'b1;
        end else begin
            ff1 <= async_in;
            ff2 <= ff1;
            ff3 <= ff2;
        end
    end

    assign rx_s       = ff2;
    assign start_edge = ff3 & ~ff2;

endmodule

// File: rtl/uart_rx_nq.sv
// 8N1 UART receiver sharing the transmitter's {DBH,DBL} divisor; rdy rises ~9.5 bit periods after start.
// No backpressure: a byte landing while rdy is set overwrites rx_data and raises ovr_err.
module uart_rx_nq
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    input  logic [7:0] DBL,
    input  logic [4:0] DBH,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output logic       ovr_err
);

    localparam int                CNT_W    = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_BITS - 1);

    rx_state_t              state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DIV_W-1:0]       baud_cnt;
    logic [DIV_W-1:0]       div_lat;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [DIV_W-1:0]       div_in;
    logic                   rx_s;
    logic                   start_edge;
    logic                   sample;

    assign div_in = {DBH, DBL};
    assign sample = (state != IDLE) && (baud_cnt == '0);

    uart_rx_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .async_in   (RX),
        .rx_s       (rx_s),
        .start_edge (start_edge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            baud_cnt  <= RST_DIV;
            div_lat   <= RST_DIV;
            shift_reg <= '0;
            rx_data   <= '0;
            rdy       <= 1'b0;
            frm_err   <= 1'b0;
            ovr_err   <= 1'b0;
        end else begin
            // Completion in the STOP branch below overrides this clear in the same cycle.
            if (clr_rdy) begin
                rdy     <= 1'b0;
                frm_err <= 1'b0;
                ovr_err <= 1'b0;
            end

            if (state != IDLE) begin
                baud_cnt <= sample ? div_lat : baud_cnt - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        div_lat  <= div_in;
                        baud_cnt <= half_period(div_in);
                        bit_cnt  <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (sample) begin
                        state <= rx_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (sample) begin
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (sample) begin
                        rx_data <= shift_reg;
                        rdy     <= 1'b1;
                        frm_err <= ~rx_s;
                        ovr_err <= ovr_err | rdy;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_nq.sv
// Randomized bench for uart_rx_nq: frame-level reference model compared against the outputs every cycle.
module tb_uart_rx_nq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] DBL;
    logic [4:0] DBH;
    logic [7:0] rx_data;
    logic       rdy;
    logic       frm_err;
    logic       ovr_err;

    uart_rx_nq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .DBL     (DBL),
        .DBH     (DBH),
        .rx_data (rx_data),
        .rdy     (rdy),
        .frm_err (frm_err),
        .ovr_err (ovr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame posted by the sender: completion clock and expected contents.
    int         pend_id = 0;
    int         pend_c  = 0;
    logic [7:0] pend_byte = 8'h00;
    bit         pend_stop = 1'b1;
    int         last_fall = 0;
    int         dv = 434;

    // Literal expectations requested by the sender.
    int         lit_id = 0;
    logic [7:0] lit_data = 8'h00;
    bit         lit_rdy = 1'b0;
    bit         lit_frm = 1'b0;
    bit         lit_ovr = 1'b0;
    int         lit_fall = -1;

    // Model state owned by the compare process.
    int         done_id = 0;
    int         lit_done = 0;
    logic [7:0] exp_data = 8'h00;
    bit         exp_rdy = 1'b0;
    bit         exp_frm = 1'b0;
    bit         exp_ovr = 1'b0;
    int         last_rise = -1;
    bit         prev_rdy = 1'b0;
    int         diff;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, req, cyc);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        #1;
        if (rst_n !== 1'b1) begin
            exp_data = 8'h00;
            exp_rdy  = 1'b0;
            exp_frm  = 1'b0;
            exp_ovr  = 1'b0;
            done_id  = pend_id;
        end else if (pend_id != done_id && cyc == pend_c) begin
            exp_ovr  = exp_ovr | exp_rdy;
            exp_rdy  = 1'b1;
            exp_data = pend_byte;
            exp_frm  = !pend_stop;
            done_id  = pend_id;
        end else if (clr_rdy) begin
            exp_rdy = 1'b0;
            exp_frm = 1'b0;
            exp_ovr = 1'b0;
        end
        chk("rx_data", int'(rx_data), int'(exp_data));
        chk("rdy",     int'(rdy),     int'(exp_rdy));
        chk("frm_err", int'(frm_err), int'(exp_frm));
        chk("ovr_err", int'(ovr_err), int'(exp_ovr));

        if (rdy && !prev_rdy) last_rise = cyc;
        prev_rdy = rdy;

        if (lit_id != lit_done) begin
            chk("lit_rx_data", int'(rx_data), int'(lit_data));
            chk("lit_rdy",     int'(rdy),     int'(lit_rdy));
            chk("lit_frm_err", int'(frm_err), int'(lit_frm));
            chk("lit_ovr_err", int'(ovr_err), int'(lit_ovr));
            if (lit_fall >= 0) begin
                diff = last_rise - lit_fall;
                checks++;
                if (diff < 4133 || diff > 4137) begin
                    errors++;
                    $display("FAIL rdy_latency: got %0d clocks expected 4135 +/- 2", diff);
                end
            end
            lit_done = lit_id;
        end
    end

    task automatic set_div(input int d);
        @(negedge clk);
        {DBH, DBL} = 13'(d);
        dv = d;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
    endtask

    task automatic expect_lit(input logic [7:0] d, input bit r, input bit fe, input bit oe, input int fall);
        @(negedge clk);
        lit_data = d;
        lit_rdy  = r;
        lit_frm  = fe;
        lit_ovr  = oe;
        lit_fall = fall;
        lit_id++;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Frame completes 3 clocks of sync, half a period, then nine full periods after the fall, plus the output flop.
    task automatic send_frame(input logic [7:0] b, input bit stop, input int hold_low,
                              input int chg_bit, input logic [12:0] chg_d,
                              input int rst_bit, input bit clr_hit);
        int f;
        int p;
        p = dv + 1;
        @(negedge clk);
        RX = 1'b0;
        f = cyc;
        last_fall = f;
        pend_c    = f + dv / 2 + 4 + 9 * p;
        pend_byte = b;
        pend_stop = stop;
        pend_id++;
        repeat (p) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_bit) begin
                rst_n = 1'b0;
                RX    = 1'b1;
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                repeat (4) @(negedge clk);
                return;
            end
            if (i == chg_bit) {DBH, DBL} = chg_d;
            RX = b[i];
            repeat (p) @(negedge clk);
        end
        RX = stop;
        for (int j = 0; j < p; j++) begin
            clr_rdy = clr_hit && (cyc == pend_c - 1);
            @(negedge clk);
        end
        clr_rdy = 1'b0;
        repeat (hold_low) @(negedge clk);
        RX = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [7:0] rb;
        bit         rs;
        RX      = 1'b1;
        clr_rdy = 1'b0;
        rst_n   = 1'b0;
        {DBH, DBL} = 13'h01B2;
        dv = 434;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expect_lit(8'h00, 1'b0, 1'b0, 1'b0, -1);

        // Nominal byte with latency window.
        send_frame(8'hA5, 1'b1, 0, -1, 13'h0, -1, 1'b0);
        expect_lit(8'hA5, 1'b1, 1'b0, 1'b0, last_fall);

        // Glitch shorter than half a bit is rejected.
        @(negedge clk);
        RX = 1'b0;
        repeat (100) @(negedge clk);
        RX = 1'b1;
        repeat (600) @(negedge clk);
        expect_lit(8'hA5, 1'b1, 1'b0, 1'b0, -1);
        pulse_clr();
        expect_lit(8'hA5, 1'b0, 1'b0, 1'b0, -1);

        // Framing error followed by a long break.
        send_frame(8'h3C, 1'b0, 2000, -1, 13'h0, -1, 1'b0);
        expect_lit(8'h3C, 1'b1, 1'b1, 1'b0, -1);
        pulse_clr();
        expect_lit(8'h3C, 1'b0, 1'b0, 1'b0, -1);

        // Overrun, then clr_rdy colliding with completion.
        send_frame(8'h11, 1'b1, 0, -1, 13'h0, -1, 1'b0);
        send_frame(8'h22, 1'b1, 0, -1, 13'h0, -1, 1'b0);
        expect_lit(8'h22, 1'b1, 1'b0, 1'b1, -1);
        send_frame(8'h33, 1'b1, 0, -1, 13'h0, -1, 1'b1);
        expect_lit(8'h33, 1'b1, 1'b0, 1'b1, -1);
        pulse_clr();

        // Divisor change mid-frame applies to the next frame only.
        send_frame(8'h96, 1'b1, 0, 3, 13'h0056, -1, 1'b0);
        expect_lit(8'h96, 1'b1, 1'b0, 1'b0, -1);
        pulse_clr();
        set_div(13'h0056);
        send_frame(8'hC3, 1'b1, 0, -1, 13'h0, -1, 1'b0);
        expect_lit(8'hC3, 1'b1, 1'b0, 1'b0, -1);

        // Async reset mid-frame, then a clean frame.
        set_div(13'h01B2);
        send_frame(8'hFF, 1'b1, 0, -1, 13'h0, 4, 1'b0);
        expect_lit(8'h00, 1'b0, 1'b0, 1'b0, -1);
        send_frame(8'h5A, 1'b1, 0, -1, 13'h0, -1, 1'b0);
        expect_lit(8'h5A, 1'b1, 1'b0, 1'b0, -1);

        // Random bytes, stop bits and divisors down to the minimum supported value.
        repeat (20) begin
            set_div(int'($urandom_range(4, 40)));
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rb, rs, 0, -1, 13'h0, -1, 1'b0);
            if ($urandom_range(0, 1) == 1) pulse_clr();
        end
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_nq.md
Name: uart_rx_nq

Overview:
UART receiver that consumes the serial line produced by the team's programmable-baud transmitter (8N1, LSB first, idle high). It shares that transmitter's 13-bit divisor interface {DBH,DBL}, so one baud register drives both directions. It synchronizes RX, detects the start edge, samples each bit at mid-period and presents a byte with a ready flag to the bus/SPART logic.

Parameters:
RST_DIV, 13'h01B2, divisor used when DBH/DBL are not yet meaningful (reset value of the latched divisor).
DATA_BITS, 8, payload bits per frame (fixed at 8 for this design; kept as a named constant).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
RX  input  1  asynchronous serial input, idle high
clr_rdy  input  1  consumer acknowledges byte; clears rdy, frm_err and ovr_err
DBL  input  8  divisor low byte
DBH  input  5  divisor high bits; D = {DBH,DBL}, bit period = D+1 clocks
rx_data  output  8  last received byte
rdy  output  1  byte available (set/reset flop)
frm_err  output  1  stop bit sampled low on the last frame
ovr_err  output  1  a byte completed while rdy was still set

Behaviour:
- Reset (async, rst_n low): sync flops = 1, state = IDLE, bit_cnt = 0, baud_cnt = RST_DIV, div_lat = RST_DIV, rx_data = 8'h00, rdy = 0, frm_err = 0, ovr_err = 0. Reset mid-frame aborts the frame with no rdy pulse.
- Sync: RX passes through two flops (rx_ff2), plus a third flop for edge detect. start_edge = rx_ff3 & ~rx_ff2. Detection occurs 3 clocks after the RX fall.
- Divisor: div_lat <= {DBH,DBL} on start_edge in IDLE. DBH/DBL changes mid-frame take effect on the next frame. Supported range is D >= 4; smaller values are outside the supported range.
- Baud counter: 13-bit down-counter; sample = (baud_cnt == 0) while not IDLE. It loads div_lat on every sample.
- States:
  IDLE: on start_edge, load baud_cnt = {DBH,DBL}>>1 (half period), bit_cnt = 0, go to START.
  START: on sample, if rx_ff2 == 1 (false start / glitch), return to IDLE with no flag change. Otherwise go to DATA.
  DATA: on each sample, shift_reg <= {rx_ff2, shift_reg[7:1]}, bit_cnt++. After the 8th data sample (bit_cnt == 8), go to STOP.
  STOP: on sample, rx_data <= shift_reg, rdy <= 1, frm_err <= ~rx_ff2, ovr_err <= ovr_err | rdy. Return to IDLE.
- Timing: rdy rises in the clock after the stop-bit mid-sample, about 9.5 bit periods after start_edge. The data byte is still delivered on a framing error.
- Back-to-back frames: IDLE re-arms immediately after the stop sample, so a start edge half a bit later is caught.
- Simultaneous clr_rdy and frame completion: completion wins. rdy = 1, and flags take the new frame's values (ovr_err computed from rdy before the clear).
- clr_rdy with no pending byte: no effect apart from clearing the flags.
- Overrun: rx_data is overwritten by the newest byte, and ovr_err stays set until clr_rdy.
- RX held low (break): the frame completes with frm_err = 1. No new start_edge fires until RX returns high.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum {IDLE, START, DATA, STOP}
  - RST_DIV = 13'h01B2
  - DATA_BITS = 8
  - divisor width 13
  - The transmitter's reset divisor is to be migrated to this package.
- Sub-module uart_rx_sync: 3-flop synchronizer with reset-to-1 and falling-edge detect. Outputs rx_s and start_edge; reusable for CTS-type inputs.

Test Plan:
- Nominal byte: D = 0x1B2 (435-clk bit), send 8'hA5 with stop = 1. Expect rx_data = 8'hA5, rdy = 1, frm_err = 0, ovr_err = 0. rdy rises 3 + 217 + 9×435 ± 2 clocks after the RX fall.
- Glitch rejection: RX low for 100 clocks, then high. Expect state back to IDLE after the half-bit sample; rdy, rx_data and flags unchanged.
- Framing and break: send 8'h3C with stop bit = 0. Expect rx_data = 8'h3C, rdy = 1, frm_err = 1. Then clr_rdy gives rdy = 0, frm_err = 0.
- Overrun and collision: send 8'h11 then 8'h22 with no clr_rdy. Expect rx_data = 8'h22, ovr_err = 1. Assert clr_rdy in the exact completion cycle of a third byte 8'h33: expect rdy = 1, ovr_err = 1, rx_data = 8'h33.
- Divisor change mid-frame: start a frame at D = 0x1B2 and switch DBH/DBL to 0x0056 at bit 3. The frame is received correctly at the old rate. The next frame, 8'hC3 at the 87-clk bit period, is received correctly.
- Async reset mid-frame at bit 4: all outputs go to reset values immediately. The following clean frame 8'h5A is received correctly with no ovr_err.
